// File: rtl/stream_rx_fifo.sv
// stream_rx_fifo: show-ahead receive buffer; upstream cannot be stalled, so a word arriving while full is dropped and flagged.
// Latency: a pushed word appears on dout/valid_out one cycle after its push (no din->dout bypass).
// Backpressure: ready_in stalls the head word; optional drop counter enabled by `define STREAM_RX_DROP_CNT_EN.
module stream_rx_fifo #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [width-1:0]       din,
  input  logic                   valid_in,
  output logic [width-1:0]       dout,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count,
  output logic                   overflow,
  input  logic                   ovf_clr
`ifdef STREAM_RX_DROP_CNT_EN
  ,
  output logic [7:0]             drop_cnt
`endif
);

  localparam int              AW       = $clog2(depth);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(depth);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

  logic [width-1:0] r_mem [depth];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             r_ovf;

  logic w_pop;
  logic w_push;
  logic w_drop;

  // Flags decode straight from the registered occupancy.
  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign valid_out = !empty;
  assign dout      = r_mem[r_rptr];
  assign count     = r_count;
  assign overflow  = r_ovf;

  // A pop frees a slot in the same cycle, so a full buffer can still accept a word alongside it.
  always_comb begin
    w_pop  = valid_out && ready_in;
    w_push = valid_in && (!full || w_pop);
    w_drop = valid_in && full && !w_pop;
  end

  // Payload storage; no reset needed because the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef STREAM_RX_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  assign drop_cnt = r_drop_cnt;

  // Saturating drop counter; a clear coinciding with a drop restarts the count at that drop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (ovf_clr)                  r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      r_drop_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_stream_rx_fifo.sv
// Directed bench for stream_rx_fifo: reset, fill/drain, drop handling, full+pop, latency, wrap, mid-stream reset.
module tb_stream_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       valid_in;
  logic [7:0] dout;
  logic       valid_out;
  logic       ready_in;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       ovf_clr;
`ifdef STREAM_RX_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  stream_rx_fifo #(.width(8), .depth(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .valid_in  (valid_in),
    .dout      (dout),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
`ifdef STREAM_RX_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load 8 consecutive words starting at base with the consumer stalled.
  task automatic fill(input logic [7:0] base);
    ready_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      din      = base + 8'(i);
      valid_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; din = '0; valid_in = 1'b0; ready_in = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    tests++; if (empty !== 1'b1)     begin fails++; $display("FAIL reset_empty: got %b want 1", empty); end
    tests++; if (full !== 1'b0)      begin fails++; $display("FAIL reset_full: got %b want 0", full); end
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    tests++; if (count !== 4'd0)     begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
    tests++; if (overflow !== 1'b0)  begin fails++; $display("FAIL reset_ovf: got %b want 0", overflow); end
`ifdef STREAM_RX_DROP_CNT_EN
    tests++; if (drop_cnt !== 8'd0)  begin fails++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
`endif
    rst = 1'b1;
  endtask

  task automatic test_fill_drain();
    fill(8'h01);
    tests++; if (full !== 1'b1)  begin fails++; $display("FAIL fill_full: got %b want 1", full); end
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL fill_count: got %0d want 8", count); end
    ready_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tests++;
      if (valid_out !== 1'b1 || dout !== 8'(i)) begin
        fails++; $display("FAIL drain_word%0d: got v=%b d=%02h want v=1 d=%02h", i, valid_out, dout, 8'(i));
      end
      tick();
    end
    ready_in = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_overflow();
    fill(8'h10);
    din = 8'hAA; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", overflow); end
    tests++; if (count !== 4'd8)    begin fails++; $display("FAIL ovf_count: got %0d want 8", count); end
`ifdef STREAM_RX_DROP_CNT_EN
    tests++; if (drop_cnt !== 8'd1) begin fails++; $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt); end
`endif
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clr: got %b want 0", overflow); end
`ifdef STREAM_RX_DROP_CNT_EN
    tests++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL ovf_clr_drop_cnt: got %0d want 0", drop_cnt); end
`endif
    // Clear and drop on the same edge: the drop must win.
    din = 8'hAB; valid_in = 1'b1; ovf_clr = 1'b1;
    tick();
    valid_in = 1'b0; ovf_clr = 1'b0;
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
`ifdef STREAM_RX_DROP_CNT_EN
    tests++; if (drop_cnt !== 8'd1) begin fails++; $display("FAIL ovf_clr_drop_cnt_one: got %0d want 1", drop_cnt); end
`endif
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (valid_out !== 1'b1 || dout !== 8'h10 + 8'(i)) begin
        fails++; $display("FAIL ovf_drain%0d: got v=%b d=%02h want v=1 d=%02h", i, valid_out, dout, 8'h10 + 8'(i));
      end
      tick();
    end
    ready_in = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL ovf_drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_full_pop();
    fill(8'h20);
    ready_in = 1'b1; din = 8'h55; valid_in = 1'b1;
    tests++; if (dout !== 8'h20) begin fails++; $display("FAIL fullpop_head: got %02h want 20", dout); end
    tick();
    valid_in = 1'b0; ready_in = 1'b0;
    tests++; if (count !== 4'd8)    begin fails++; $display("FAIL fullpop_count: got %0d want 8", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp;
      exp = (i < 7) ? 8'h21 + 8'(i) : 8'h55;
      tests++;
      if (valid_out !== 1'b1 || dout !== exp) begin
        fails++; $display("FAIL fullpop_drain%0d: got v=%b d=%02h want v=1 d=%02h", i, valid_out, dout, exp);
      end
      tick();
    end
    ready_in = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL fullpop_empty: got %b want 1", empty); end
  endtask

  task automatic test_empty_latency();
    ready_in = 1'b1; din = 8'h3C; valid_in = 1'b1;
    #1;
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL lat_no_bypass: got %b want 0", valid_out); end
    tick();
    valid_in = 1'b0;
    tests++;
    if (valid_out !== 1'b1 || dout !== 8'h3C) begin
      fails++; $display("FAIL lat_n1: got v=%b d=%02h want v=1 d=3c", valid_out, dout);
    end
    tick();
    ready_in = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL lat_n2_empty: got %b want 1", empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    int  sent = 0;
    int  recv = 0;
    int  cyc  = 0;
    bit  pop, push;
    while ((sent < 20 || q.size() != 0) && cyc < 400) begin
      ready_in = 1'($urandom_range(0, 1));
      pop      = ready_in && (q.size() != 0);
      push     = (sent < 20) && (q.size() < 8 || pop);
      valid_in = push;
      din      = 8'h80 + 8'(sent);
      #1;
      tests++;
      if (count !== 4'(q.size())) begin
        fails++; $display("FAIL wrap_count c%0d: got %0d want %0d", cyc, count, q.size());
      end
      if (pop) begin
        tests++;
        if (valid_out !== 1'b1 || dout !== q[0]) begin
          fails++; $display("FAIL wrap_word%0d: got v=%b d=%02h want v=1 d=%02h", recv, valid_out, dout, q[0]);
        end
        void'(q.pop_front());
        recv++;
      end
      if (push) begin
        q.push_back(din);
        sent++;
      end
      tick();
      cyc++;
    end
    valid_in = 1'b0; ready_in = 1'b0;
    tests++; if (recv != 20) begin fails++; $display("FAIL wrap_received: got %0d want 20", recv); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL wrap_empty: got %b want 1", empty); end
  endtask

  task automatic test_reset_midstream();
    fill(8'h40);
    din = 8'hEE; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; ready_in = 1'b1;
    tick(); tick(); tick();
    ready_in = 1'b0;
    tests++; if (count !== 4'd5)    begin fails++; $display("FAIL mid_pre_count: got %0d want 5", count); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL mid_pre_ovf: got %b want 1", overflow); end
    rst = 1'b0; din = 8'h99; valid_in = 1'b1;
    tick();
    rst = 1'b1; valid_in = 1'b0;
    tests++; if (count !== 4'd0)     begin fails++; $display("FAIL mid_count: got %0d want 0", count); end
    tests++; if (empty !== 1'b1)     begin fails++; $display("FAIL mid_empty: got %b want 1", empty); end
    tests++; if (overflow !== 1'b0)  begin fails++; $display("FAIL mid_ovf: got %b want 0", overflow); end
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b want 0", valid_out); end
    // First edge with reset released must accept a push.
    din = 8'h77; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tests++;
    if (valid_out !== 1'b1 || dout !== 8'h77 || count !== 4'd1) begin
      fails++; $display("FAIL post_rst_push: got v=%b d=%02h c=%0d want v=1 d=77 c=1", valid_out, dout, count);
    end
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL post_rst_drain: got %b want 1", empty); end
  endtask

`ifdef STREAM_RX_DROP_CNT_EN
  task automatic test_saturation();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    fill(8'h60);
    din = 8'hDD; valid_in = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    valid_in = 1'b0;
    tests++; if (drop_cnt !== 8'd255) begin fails++; $display("FAIL sat_drop_cnt: got %0d want 255", drop_cnt); end
    tests++; if (count !== 4'd8)      begin fails++; $display("FAIL sat_count: got %0d want 8", count); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    tests++; if (drop_cnt !== 8'd0)   begin fails++; $display("FAIL sat_clr: got %0d want 0", drop_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_pop();
    test_empty_latency();
    test_wrap();
    test_reset_midstream();
`ifdef STREAM_RX_DROP_CNT_EN
    test_saturation();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_rx_fifo.md
STREAM_RX_FIFO -- requirements
Module: stream_rx_fifo

Interface
REQ-001 The block SHALL have parameter width, default 8, giving the payload width in bits.
REQ-002 The block SHALL have parameter depth, default 8, giving the number of buffer entries; legal values are powers of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port din, input, width bits: upstream payload.
REQ-006 The block SHALL have port valid_in, input, 1 bit: din qualifier; upstream has no backpressure.
REQ-007 The block SHALL have port dout, output, width bits: head-of-buffer payload.
REQ-008 The block SHALL have port valid_out, output, 1 bit: dout is valid.
REQ-009 The block SHALL have port ready_in, input, 1 bit: downstream accepts dout.
REQ-010 The block SHALL have port full, output, 1 bit: the buffer holds depth entries.
REQ-011 The block SHALL have port empty, output, 1 bit: the buffer holds 0 entries.
REQ-012 The block SHALL have port count, output, $clog2(depth)+1 bits: current occupancy.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag indicating at least one word was dropped.
REQ-014 The block SHALL have port ovf_clr, input, 1 bit: clears overflow.

Function
REQ-015 The block SHALL perform a push when valid_in=1 and (full=0 or a pop occurs in the same cycle).
REQ-016 The block SHALL perform a pop when valid_out=1 and ready_in=1.
REQ-017 The block SHALL drive valid_out = !empty; dout SHALL equal the entry at the read pointer, so dout is show-ahead with no read latency.
REQ-018 The block SHALL make a word pushed in cycle N visible at dout/valid_out in cycle N+1; there is no same-cycle bypass from din to dout when empty.
REQ-019 The block SHALL wrap its read and write pointers modulo depth; words SHALL emerge in strict push order.
REQ-020 The block SHALL update count by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop; full = (count==depth) and empty = (count==0), both decoded from registered state.
REQ-021 The block SHALL discard din when valid_in=1, full=1 and no pop occurs, leaving the buffer contents, pointers and count unchanged.
REQ-022 The block SHALL set overflow on the cycle after a discard; overflow SHALL remain set until ovf_clr=1 or reset.
REQ-023 The block SHALL keep overflow set if ovf_clr=1 and a discard occur in the same cycle (set wins).
REQ-024 The block SHALL hold dout stable while valid_out=1 and ready_in=0.
REQ-025 The block SHALL ignore ready_in when empty=1, with no pointer movement and no underflow.

Reset
REQ-026 The block SHALL, when rst=0 at a clock edge, clear the pointers and count, giving empty=1, full=0, valid_out=0, count=0 and overflow=0; dout is don't-care while valid_out=0.
REQ-027 The block SHALL discard all buffered words on a reset asserted mid-stream and SHALL ignore valid_in during reset.
REQ-028 The block SHALL accept the first push on the first edge at which rst=1.

Configuration
REQ-029 The block SHALL, when macro STREAM_RX_DROP_CNT_EN is defined, add output drop_cnt, 8 bits, reset 0, which increments on each discard, saturates at 255, and is cleared by ovf_clr unless a discard occurs in the same cycle, in which case drop_cnt becomes 1.
REQ-030 The block SHALL, without STREAM_RX_DROP_CNT_EN, have no drop_cnt port and no associated logic; all other behaviour SHALL be identical.

Verification
REQ-031 Fill and drain: 8 pushes of 0x01..0x08 with ready_in=0 -> full=1, count=8; then ready_in=1 -> dout 0x01..0x08 on consecutive cycles, then empty=1.
REQ-032 Overflow: on a full buffer, push 0xAA with ready_in=0 -> 0xAA never appears, overflow=1 next cycle, drop_cnt=1 if enabled; ovf_clr=1 -> overflow=0.
REQ-033 Full with simultaneous pop: full, ready_in=1, push 0x55 -> no drop, count stays 8, 0x55 emerges 8th after the popped word.
REQ-034 Empty latency: push 0x3C at cycle N with ready_in=1 -> valid_out=0 at N, valid_out=1 with dout=0x3C at N+1, empty=1 at N+2.
REQ-035 Wrap and reset: stream 20 words with random ready_in -> output order is exact; rst=0 with 5 entries buffered -> count=0, empty=1, overflow=0 next cycle.
REQ-036 Saturation (macro on): 300 discards -> drop_cnt=255.
